// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data memory controller
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, write replication and read extraction
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wbe,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    // Replicate write data across lanes and pull the addressed lane(s) down to bit 0
    always_comb begin
        wbe       = 4'b0000;
        wdata_rep = wdata;
        rdata     = 32'd0;
        shifted   = rword >> {lane, 3'b000};
        case (size)
            SZ_BYTE: begin
                wbe       = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wbe       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                wbe   = 4'b1111;
                rdata = rword;
            end
            default: begin
                wbe = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - variable-latency byte-laned data memory with stall handshake
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sext,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        mem_err,
    output logic [31:0] mem_badaddr
);

    localparam int  DEPTH     = 2 ** ADDR_WIDTH;
    localparam int  CNT_W     = $clog2(LATENCY_MAX + 1);
    localparam bit  ZERO_LAT  = (LATENCY == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic [31:0] req_addr;
    logic [31:0] req_din;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        req_wen;

    logic        req;
    logic        illegal;
    logic        in_idle;
    logic        commit;
    logic [31:0] acc_addr;
    logic [31:0] acc_din;
    logic [1:0]  acc_size;
    logic        acc_sext;
    logic        acc_wen;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            wbe;
    logic [31:0]           wdata_rep;
    logic [31:0]           rdata;

    logic [31:0] mem_array [DEPTH];

    assign req       = mem_ren | mem_wen;
    assign in_idle   = (state == ST_IDLE);
    assign mem_stall = (in_idle & req) | (state == ST_BUSY);

    // In IDLE the live inputs drive the access (zero-latency path); later the latched copy does
    assign acc_addr = in_idle ? mem_addr : req_addr;
    assign acc_din  = in_idle ? mem_din  : req_din;
    assign acc_size = in_idle ? mem_size : req_size;
    assign acc_sext = in_idle ? mem_sext : req_sext;
    assign acc_wen  = in_idle ? mem_wen  : req_wen;
    assign word_idx = acc_addr[ADDR_WIDTH+1:2];

    assign commit = (in_idle & req & ~illegal & ZERO_LAT) |
                    ((state == ST_BUSY) && (cnt == '0));

    // Classify the presented request as illegal (conflict, size, alignment, range)
    always_comb begin
        illegal = 1'b0;
        if (mem_ren && mem_wen)                          illegal = 1'b1;
        if (mem_size == 2'b11)                           illegal = 1'b1;
        if (mem_size == SZ_HALF && mem_addr[0])          illegal = 1'b1;
        if (mem_size == SZ_WORD && mem_addr[1:0] != 2'b00) illegal = 1'b1;
        if ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0)     illegal = 1'b1;
    end

    mem_lane_align u_align (
        .size      (acc_size),
        .lane      (acc_addr[1:0]),
        .sext      (acc_sext),
        .wdata     (acc_din),
        .rword     (mem_array[word_idx]),
        .wbe       (wbe),
        .wdata_rep (wdata_rep),
        .rdata     (rdata)
    );

    // Byte-enabled array write on the edge entering DONE; reset drops an uncommitted write
    always_ff @(posedge clk) begin
        if (!rst && commit && acc_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem_array[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Access FSM with latency counter and registered completion/error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mem_dout    <= 32'd0;
            mem_done    <= 1'b0;
            mem_err     <= 1'b0;
            mem_badaddr <= 32'd0;
            req_addr    <= 32'd0;
            req_din     <= 32'd0;
            req_size    <= SZ_BYTE;
            req_sext    <= 1'b0;
            req_wen     <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        req_addr <= mem_addr;
                        req_din  <= mem_din;
                        req_size <= mem_size;
                        req_sext <= mem_sext;
                        req_wen  <= mem_wen;
                        if (illegal) begin
                            state       <= ST_ERR;
                            mem_err     <= 1'b1;
                            mem_badaddr <= mem_addr;
                        end else if (ZERO_LAT) begin
                            state    <= ST_DONE;
                            mem_done <= 1'b1;
                            if (!mem_wen) mem_dout <= rdata;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state    <= ST_DONE;
                        mem_done <= 1'b1;
                        if (!req_wen) mem_dout <= rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
